// File: rtl/ibex_xif_fetch_responder_if.sv
// Core-side fetch handshake and OBI-style instruction bus of the fetch responder.
// slave is the responder's view; master is the core/bus environment's view.
interface ibex_xif_fetch_responder_if;
  logic        req;
  logic        branch;
  logic [31:0] branch_addr;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic        err;
  logic        err_plus2;
  logic        enable;
  logic        invalidate;
  logic        busy;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  modport slave (
    input  req, branch, branch_addr, ready, enable, invalidate,
           instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    output valid, rdata, addr, err, err_plus2, busy, instr_req_o, instr_addr_o
  );

  modport master (
    output req, branch, branch_addr, ready, enable, invalidate,
           instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
    input  valid, rdata, addr, err, err_plus2, busy, instr_req_o, instr_addr_o
  );
endinterface

// File: rtl/ibex_xif_fetch_responder.sv
// Cacheless stand-in for the instruction cache: fetches words over the instruction bus
// and returns them in order to the core through a small response FIFO.
module ibex_xif_fetch_responder #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned INV_CYCLES      = 8
) (
  input logic clk,
  input logic rst_n,
  ibex_xif_fetch_responder_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INV_W = $clog2(INV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(NUM_OUTSTANDING);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INV_CYCLES);

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      resp_addr_q, resp_addr_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic             pend_q, pend_d;
  logic             stale_q, stale_d;
  logic             halted_q, halted_d;

  logic             can_issue, gnt_fire, stale_gnt, drop, push, pop, fifo_nempty;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      target;
  entry_t           head;
  logic             unused_inputs;

  assign unused_inputs = bus.enable ^ (^bus.branch_addr[1:0]);
  assign target        = {bus.branch_addr[31:2], 2'b00};
  assign occupancy     = {1'b0, outstanding_q} + {1'b0, count_q};

  assign can_issue = bus.req & ~bus.branch & ~halted_q & (inv_cnt_q == '0) &
                     (outstanding_q < MAX_OUT) & (occupancy < DEPTH_X);

  // An ungranted request is held with its address regardless of branch/req/invalidate.
  assign bus.instr_req_o  = pend_q | can_issue;
  assign bus.instr_addr_o = pend_q ? pend_addr_q : fetch_addr_q;

  assign gnt_fire  = bus.instr_req_o & bus.instr_gnt_i;
  // A held request that was overtaken by a branch belongs to the old stream.
  assign stale_gnt = gnt_fire & pend_q & stale_q;
  assign drop      = discard_q != '0;
  assign push      = bus.instr_rvalid_i & ~bus.branch & ~drop;

  assign fifo_nempty   = count_q != '0;
  assign head          = mem_q[rd_ptr_q];
  assign bus.valid     = fifo_nempty & ~bus.branch;
  assign bus.rdata     = fifo_nempty ? head.rdata : '0;
  assign bus.addr      = fifo_nempty ? head.addr : '0;
  assign bus.err       = fifo_nempty & head.err;
  assign bus.err_plus2 = 1'b0;
  assign pop           = bus.valid & bus.ready;

  assign bus.busy = (outstanding_q != '0) | (inv_cnt_q != '0) | bus.invalidate;

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    resp_addr_d   = resp_addr_q;
    halted_d      = halted_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(bus.instr_rvalid_i);
    pend_d        = bus.instr_req_o & ~bus.instr_gnt_i;
    pend_addr_d   = bus.instr_addr_o;
    stale_d       = stale_q;
    if (gnt_fire) begin
      stale_d = 1'b0;
    end else if (bus.branch & pend_q) begin
      stale_d = 1'b1;
    end
    if (bus.invalidate) begin
      inv_cnt_d = INV_LOAD;
    end else if (inv_cnt_q != '0) begin
      inv_cnt_d = inv_cnt_q - INV_W'(1);
    end else begin
      inv_cnt_d = '0;
    end

    if (bus.branch) begin
      // Everything still in flight after this cycle predates the redirect.
      fetch_addr_d = target;
      resp_addr_d  = target;
      halted_d     = 1'b0;
      discard_d    = outstanding_d;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (gnt_fire & ~stale_gnt) begin
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
      if (push) begin
        resp_addr_d = resp_addr_q + 32'd4;
        wr_ptr_d    = wr_ptr_q + PTR_W'(1);
        if (bus.instr_err_i) begin
          halted_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      discard_d = discard_q + CNT_W'(stale_gnt) - CNT_W'(bus.instr_rvalid_i & drop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q  <= '0;
      resp_addr_q   <= '0;
      pend_addr_q   <= '0;
      pend_q        <= 1'b0;
      stale_q       <= 1'b0;
      halted_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      inv_cnt_q     <= '0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
      pend_addr_q   <= pend_addr_d;
      pend_q        <= pend_d;
      stale_q       <= stale_d;
      halted_q      <= halted_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      inv_cnt_q     <= inv_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.instr_rdata_i, resp_addr_q, bus.instr_err_i};
    end
  end

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    bus.instr_rvalid_i |-> outstanding_q != '0);

  a_branch_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
    bus.branch |-> !$isunknown(bus.branch_addr));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> count_q != DEPTH);

  a_output_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.valid & ~bus.ready & ~bus.branch) |=>
      (bus.branch | (bus.valid & $stable(bus.rdata) & $stable(bus.addr) & $stable(bus.err))));

endmodule

// File: tb/tb_ibex_xif_fetch_responder.sv
// Directed bench for ibex_xif_fetch_responder: a bus responder model, expected words
// queued at stimulus time, and a monitor that checks every accepted output beat.
module tb_ibex_xif_fetch_responder;
  localparam logic [31:0] MAGIC = 32'hC0DE_5A5A;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ibex_xif_fetch_responder_if f ();

  ibex_xif_fetch_responder #(
    .FIFO_DEPTH     (4),
    .NUM_OUTSTANDING(2),
    .INV_CYCLES     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (f)
  );

  exp_t        exp_q[$];
  logic [31:0] bq[$];
  int          checks     = 0;
  int          errors     = 0;
  int          gnt_cnt    = 0;
  int          max_out    = 0;
  int          rsp_budget = 1000000;
  logic        err_en     = 1'b0;
  logic [31:0] err_addr   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_word(input logic [31:0] a, input logic e);
    exp_t x;
    x.rdata = a ^ MAGIC;
    x.addr  = a;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  task automatic do_branch(input logic [31:0] a);
    f.branch      = 1'b1;
    f.branch_addr = a;
    cyc();
    f.branch      = 1'b0;
  endtask

  task automatic stop_after(input string name, input int target);
    int n = 0;
    while (gnt_cnt < target && n < 200) begin
      cyc();
      n++;
    end
    f.req = 1'b0;
    chk(name, gnt_cnt, target);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || f.valid || f.busy) && n < 100) begin
      cyc();
      n++;
    end
    chk({name, "_queue"}, exp_q.size(), 0);
    chk({name, "_idle"}, {30'b0, f.valid, f.busy}, 0);
    repeat (2) cyc();
  endtask

  // Bus responder: answers granted requests in order, one cycle after grant at the earliest.
  initial begin : bus_model
    logic        fire;
    logic [31:0] fa;
    logic [31:0] ra;
    f.instr_rvalid_i = 1'b0;
    f.instr_rdata_i  = '0;
    f.instr_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      fire = f.instr_req_o & f.instr_gnt_i & rst_n;
      fa   = f.instr_addr_o;
      @(posedge clk);
      if (fire) begin
        bq.push_back(fa);
        gnt_cnt++;
        if (bq.size() > max_out) max_out = bq.size();
      end
      #1;
      if (bq.size() != 0 && rsp_budget > 0) begin
        ra = bq.pop_front();
        rsp_budget--;
        f.instr_rvalid_i = 1'b1;
        f.instr_rdata_i  = ra ^ MAGIC;
        f.instr_err_i    = err_en && (ra == err_addr);
      end else begin
        f.instr_rvalid_i = 1'b0;
        f.instr_rdata_i  = '0;
        f.instr_err_i    = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && f.valid && f.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%08h, required no beat", f.addr);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", f.addr, e.addr);
          chk("beat_rdata", f.rdata, e.rdata);
          chk("beat_err", 32'(f.err), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin : stimulus
    int   base;
    int   busy_cnt;
    logic req_seen;
    logic req_last;

    rst_n         = 1'b0;
    f.req         = 1'b0;
    f.branch      = 1'b0;
    f.branch_addr = '0;
    f.ready       = 1'b0;
    f.enable      = 1'b0;
    f.invalidate  = 1'b0;
    f.instr_gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(f.valid), 0);
    chk("rst_instr_req", 32'(f.instr_req_o), 0);
    chk("rst_instr_addr", f.instr_addr_o, 0);
    chk("rst_busy", 32'(f.busy), 0);
    chk("rst_rdata", f.rdata, 0);
    chk("rst_addr", f.addr, 0);
    chk("rst_err", {31'b0, f.err}, 0);
    chk("rst_err_plus2", {31'b0, f.err_plus2}, 0);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    f.enable = 1'b1;
    cyc();
    chk("idle_no_req", 32'(f.instr_req_o), 0);

    // Streaming
    f.ready = 1'b1;
    base    = gnt_cnt;
    for (int i = 0; i < 8; i++) expect_word(32'h100 + 32'(4 * i), 1'b0);
    f.req = 1'b1;
    do_branch(32'h100);
    stop_after("stream_grants", base + 8);
    drain("stream");

    // Backpressure
    f.ready = 1'b0;
    base    = gnt_cnt;
    f.req   = 1'b1;
    do_branch(32'h100);
    repeat (8) cyc();
    chk("bp_grants", gnt_cnt - base, 4);
    chk("bp_req_low", 32'(f.instr_req_o), 0);
    chk("bp_valid", 32'(f.valid), 1);
    chk("bp_head_addr", f.addr, 32'h100);
    cyc();
    chk("bp_hold_addr", f.addr, 32'h100);
    chk("bp_hold_rdata", f.rdata, 32'h100 ^ MAGIC);
    for (int i = 0; i < 6; i++) expect_word(32'h100 + 32'(4 * i), 1'b0);
    f.ready = 1'b1;
    stop_after("bp_resume_grants", base + 6);
    drain("bp");

    // Branch with two responses outstanding and one buffered word
    f.ready    = 1'b0;
    rsp_budget = 1;
    base       = gnt_cnt;
    f.req      = 1'b1;
    do_branch(32'h1000);
    repeat (6) cyc();
    chk("br_bus_outstanding", bq.size(), 2);
    chk("br_req_low", 32'(f.instr_req_o), 0);
    chk("br_head_addr", f.addr, 32'h1000);
    for (int i = 0; i < 3; i++) expect_word(32'h2000 + 32'(4 * i), 1'b0);
    f.branch      = 1'b1;
    f.branch_addr = 32'h2003;
    f.ready       = 1'b1;
    rsp_budget    = 1000000;
    @(negedge clk);
    chk("br_cycle_valid", 32'(f.valid), 0);
    @(posedge clk);
    #2;
    f.branch = 1'b0;
    stop_after("br_grants", base + 6);
    drain("br");

    // Bus error halts fetching until the next branch
    err_en   = 1'b1;
    err_addr = 32'h108;
    base     = gnt_cnt;
    expect_word(32'h100, 1'b0);
    expect_word(32'h104, 1'b0);
    expect_word(32'h108, 1'b1);
    expect_word(32'h10C, 1'b0);
    f.req = 1'b1;
    do_branch(32'h100);
    repeat (12) cyc();
    chk("err_grants", gnt_cnt - base, 4);
    chk("err_halted_req", 32'(f.instr_req_o), 0);
    chk("err_words_out", exp_q.size(), 0);
    err_en = 1'b0;
    expect_word(32'h400, 1'b0);
    expect_word(32'h404, 1'b0);
    do_branch(32'h400);
    stop_after("err_resume_grants", base + 6);
    drain("err");

    // Address wrap
    base = gnt_cnt;
    expect_word(32'hFFFF_FFF8, 1'b0);
    expect_word(32'hFFFF_FFFC, 1'b0);
    expect_word(32'h0000_0000, 1'b0);
    f.req = 1'b1;
    do_branch(32'hFFFF_FFF8);
    stop_after("wrap_grants", base + 3);
    drain("wrap");

    // Invalidate with a full buffer
    f.ready = 1'b0;
    base    = gnt_cnt;
    for (int i = 0; i < 6; i++) expect_word(32'h300 + 32'(4 * i), 1'b0);
    f.req = 1'b1;
    do_branch(32'h300);
    stop_after("inv_fill_grants", base + 4);
    repeat (3) cyc();
    chk("inv_pre_busy", 32'(f.busy), 0);
    chk("inv_pre_valid", 32'(f.valid), 1);
    f.invalidate = 1'b1;
    f.req        = 1'b1;
    busy_cnt     = 0;
    req_seen     = 1'b0;
    req_last     = 1'b0;
    @(negedge clk);
    busy_cnt += int'(f.busy);
    req_seen |= f.instr_req_o;
    @(posedge clk);
    #2;
    f.invalidate = 1'b0;
    f.ready      = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      busy_cnt += int'(f.busy);
      if (k < 9) req_seen |= f.instr_req_o;
      else req_last = f.instr_req_o;
    end
    chk("inv_busy_cycles", busy_cnt, 9);
    chk("inv_req_blocked", 32'(req_seen), 0);
    chk("inv_req_resumes", 32'(req_last), 1);
    stop_after("inv_grants", base + 6);
    drain("inv");

    chk("max_bus_outstanding", max_out, 2);
    chk("final_err_plus2", 32'(f.err_plus2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_xif_fetch_responder.md
Name: ibex_xif_fetch_responder

Overview:
Synthesizable fetch-side responder. It sits on the cache side of the core<->icache fetch interface and stands in for the instruction cache in core-level benches and cacheless builds. It accepts the core's req, branch, ready, enable and invalidate signals. It fetches words over an OBI-style instruction bus and returns in-order {rdata, addr, err} through a small FIFO using the valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, response buffer entries (power of 2, >=2); also bounds outstanding+buffered words.
NUM_OUTSTANDING, 2, max bus requests granted but not yet answered (1..FIFO_DEPTH).
INV_CYCLES, 8, cycles busy stays high after invalidate deasserts (>=1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  1  core wants instructions
branch  in  1  redirect fetch, single-cycle pulse
branch_addr  in  32  redirect target; bits [1:0] ignored
ready  in  1  core accepts head instruction
valid  out  1  rdata/addr/err valid
rdata  out  32  instruction word
addr  out  32  word-aligned address of rdata
err  out  1  bus error for this word
err_plus2  out  1  tied 0 (word-only fetch)
enable  in  1  cache enable; no effect (no storage)
invalidate  in  1  invalidate request
busy  out  1  bus activity or invalidation in progress
instr_req_o  out  1  bus request
instr_addr_o  out  32  bus address, word aligned
instr_gnt_i  in  1  bus grant
instr_rvalid_i  in  1  bus response valid
instr_rdata_i  in  32  bus response data
instr_err_i  in  1  bus response error

Behaviour:
- Reset: all outputs 0. FIFO empty. Counters 0. fetch_addr=0, resp_addr=0. halted=0.
- Clock and reset: rst_n asynchronous, active-low; clock clk.
- Request condition: instr_req_o=1 when req & ~branch & ~halted & inv_cnt==0 & outstanding<NUM_OUTSTANDING & (outstanding+fifo_count)<FIFO_DEPTH. instr_addr_o=fetch_addr.
- Bus stability: once instr_req_o is high without gnt, instr_req_o and instr_addr_o hold stable until gnt. This holds even if branch, req low or invalidate arrive.
- On gnt: fetch_addr+=4, wrapping 0xFFFFFFFC->0. outstanding++.
- On rvalid: outstanding--.
  - If discard_cnt>0: discard_cnt--, response dropped.
  - Else: push {instr_rdata_i, resp_addr, instr_err_i} into FIFO, resp_addr+=4. If instr_err_i, halted<=1.
- Latency: a response becomes visible on valid the cycle after rvalid. There is no bypass.
- Output: valid = fifo_nonempty & ~branch. rdata/addr/err show the FIFO head. Pop when valid&ready. Push and pop in the same cycle are allowed; count is unchanged.
- halted: no new requests are issued until the next branch. Buffered words still drain.
- Branch cycle:
  - FIFO flushed.
  - fetch_addr<=resp_addr<={branch_addr[31:2],2'b00}. halted<=0.
  - discard_cnt <= outstanding + (gnt this cycle) - (rvalid this cycle).
  - A response arriving in the branch cycle is dropped.
  - A pending request granted in the branch cycle is pre-branch and is discarded when its response arrives.
  - Fetch from the new address starts the next cycle if allowed.
- Invalidate: inv_cnt<=INV_CYCLES every cycle invalidate=1. Otherwise it decrements to 0. Requests are blocked while inv_cnt!=0. FIFO contents are unaffected.
- busy = outstanding!=0 | inv_cnt!=0 | invalidate.
- req=0: no new requests. Outstanding responses are still buffered and presented.
- FIFO full: push never occurs when full, because the request condition prevents over-subscription. An assertion checks this.
- Reset mid-transfer: all state cleared. Later bus responses are the environment's responsibility.
- Assertions:
  - instr_rvalid_i is never high with outstanding==0.
  - branch_addr is known whenever branch=1.
  - valid/rdata/addr/err are stable while valid&~ready&~branch.

Test Plan:
- Streaming: rst, req=1, branch to 0x100, gnt always, rvalid 1 cycle after gnt, ready=1 -> valid words with addr 0x100,0x104,0x108,... in order. Never more than 2 outstanding.
- Backpressure: ready=0 with FIFO_DEPTH=4 -> exactly 4 words requested (0x100..0x10C) then instr_req_o=0. valid and data are held. ready=1 resumes fetching at 0x110.
- Branch with 2 outstanding: branch to 0x2000 -> both old responses dropped. First valid shows addr=0x2000 with its own rdata. valid=0 in the branch cycle.
- Bus error: instr_err_i=1 on the word at 0x108 -> valid with err=1, addr=0x108. No further instr_req_o until branch to 0x400, then fetching resumes.
- Wrap: branch to 0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Invalidate: 1-cycle invalidate pulse with INV_CYCLES=8 -> busy high for 9 cycles and instr_req_o=0 throughout. Buffered words still delivered.
